// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sharing controller and its arbiter.
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } share_state_t;

  // Requester-id width: $clog2(n), but never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after 'last', wrapping modulo N.
module rr_arbiter #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   gnt_onehot,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);

  logic           found_s;
  logic [IDW-1:0] idx_s;

  // Scan last+1 .. last+N and take the first active request.
  always_comb begin
    gnt_onehot = {N{1'b0}};
    gnt_id     = {IDW{1'b0}};
    found_s    = 1'b0;
    idx_s      = {IDW{1'b0}};
    for (int k = 1; k <= N; k++) begin
      idx_s = IDW'((int'(last) + k) % N);
      if (!found_s && req[idx_s]) begin
        found_s           = 1'b1;
        gnt_onehot[idx_s] = 1'b1;
        gnt_id            = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external ALU between NREQ requesters: round-robin grant, registered
// operands into the ALU and a held, registered response until the consumer takes it.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter  int NREQ  = 2,
  parameter  int WIDTH = ALU_W,
  localparam int IDW   = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_op1,
  input  logic [NREQ*WIDTH-1:0] req_op2,
  input  logic [NREQ*3-1:0]     req_ctrl,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_eq,
  output logic [WIDTH-1:0]      alu_op1,
  output logic [WIDTH-1:0]      alu_op2,
  output logic [2:0]            alu_ctrl,
  input  logic [WIDTH-1:0]      alu_out,
  input  logic                  alu_eq
);

  share_state_t     state_r;
  share_state_t     state_nxt_s;
  logic [IDW-1:0]   last_grant_r;
  logic [IDW-1:0]   id_r;
  logic [NREQ-1:0]  gnt_onehot_s;
  logic [IDW-1:0]   gnt_id_s;
  logic             any_s;
  logic             arb_en_s;
  logic             accept_s;
  logic [WIDTH-1:0] sel_op1_s;
  logic [WIDTH-1:0] sel_op2_s;
  logic [2:0]       sel_ctrl_s;

  rr_arbiter #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_arb (
    .req        (req_valid),
    .last       (last_grant_r),
    .gnt_onehot (gnt_onehot_s),
    .gnt_id     (gnt_id_s),
    .any        (any_s)
  );

  // Arbitration is open in IDLE, or in RESP once the held response is consumed.
  always_comb begin
    arb_en_s = 1'b0;
    case (state_r)
      S_IDLE:  arb_en_s = 1'b1;
      S_RESP:  arb_en_s = rsp_ready;
      default: arb_en_s = 1'b0;
    endcase
  end

  assign accept_s  = arb_en_s && any_s && !rst;
  assign req_ready = accept_s ? gnt_onehot_s : {NREQ{1'b0}};

  // Operand mux for the granted requester.
  always_comb begin
    sel_op1_s  = {WIDTH{1'b0}};
    sel_op2_s  = {WIDTH{1'b0}};
    sel_ctrl_s = 3'b000;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_onehot_s[i]) begin
        sel_op1_s  = req_op1[i*WIDTH +: WIDTH];
        sel_op2_s  = req_op2[i*WIDTH +: WIDTH];
        sel_ctrl_s = req_ctrl[i*3 +: 3];
      end else begin
        sel_ctrl_s = sel_ctrl_s;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s = S_EXEC;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_EXEC: state_nxt_s = S_RESP;
      S_RESP: begin
        if (!rsp_ready) begin
          state_nxt_s = S_RESP;
        end else if (accept_s) begin
          state_nxt_s = S_EXEC;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand, id and response registers; the ALU inputs only move on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op1      <= {WIDTH{1'b0}};
      alu_op2      <= {WIDTH{1'b0}};
      alu_ctrl     <= 3'b000;
      id_r         <= {IDW{1'b0}};
      last_grant_r <= IDW'(NREQ - 1);
      rsp_valid    <= 1'b0;
      rsp_id       <= {IDW{1'b0}};
      rsp_result   <= {WIDTH{1'b0}};
      rsp_eq       <= 1'b0;
    end else begin
      if (accept_s) begin
        alu_op1  <= sel_op1_s;
        alu_op2  <= sel_op2_s;
        alu_ctrl <= sel_ctrl_s;
        id_r     <= gnt_id_s;
      end
      if (state_r == S_EXEC) begin
        rsp_result   <= alu_out;
        rsp_eq       <= alu_eq;
        rsp_id       <= id_r;
        last_grant_r <= id_r;
        rsp_valid    <= 1'b1;
      end else if ((state_r == S_RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a transaction-level reference model checked every cycle.
module tb_alu_share_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_op1;
  logic [63:0] req_op2;
  logic [5:0]  req_ctrl;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_eq;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        alu_eq;

  int errors = 0;
  int checks = 0;

  alu_share_ctrl #(.NREQ(2), .WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_ctrl(req_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_eq(rsp_eq),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_eq(alu_eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU behaviour: unsupported codes give 0.
  function automatic logic [31:0] alu_ref(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Stand-in for the external ALU.
  always_comb begin
    alu_out = alu_ref(alu_ctrl, alu_op1, alu_op2);
    alu_eq  = (alu_out == 32'd0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    req_valid[i]        = 1'b1;
    req_ctrl[i*3 +: 3]  = c;
    req_op1[i*32 +: 32] = a;
    req_op2[i*32 +: 32] = b;
  endtask

  // Transaction-level model: one op in flight, one response on display, last winner.
  bit          m_inflight = 1'b0;
  bit          m_shown    = 1'b0;
  int          m_last     = 1;
  int          m_fl_id, m_sh_id;
  logic [31:0] m_fl_res, m_sh_res;
  logic [31:0] m_op1 = 32'd0, m_op2 = 32'd0;
  logic [2:0]  m_ctrl = 3'd0;

  always @(negedge clk) begin
    bit         can_acc;
    int         win;
    logic [1:0] exp_rdy;
    if (rst) begin
      m_inflight = 1'b0;
      m_shown    = 1'b0;
      m_last     = 1;
      m_op1      = 32'd0;
      m_op2      = 32'd0;
      m_ctrl     = 3'd0;
    end
    can_acc = !rst && !m_inflight && (!m_shown || rsp_ready);
    win = -1;
    for (int k = 1; k <= 2; k++) begin
      if (win < 0 && req_valid[(m_last + k) % 2]) win = (m_last + k) % 2;
    end
    exp_rdy = (can_acc && win >= 0) ? (2'b01 << win) : 2'b00;
    chk("m_req_ready", {62'd0, req_ready}, {62'd0, exp_rdy});
    chk("m_rsp_valid", {63'd0, rsp_valid}, {63'd0, m_shown});
    if (m_shown) begin
      chk("m_rsp_id", {63'd0, rsp_id}, 64'(m_sh_id));
      chk("m_rsp_result", {32'd0, rsp_result}, {32'd0, m_sh_res});
      chk("m_rsp_eq", {63'd0, rsp_eq}, {63'd0, (m_sh_res == 32'd0)});
    end
    chk("m_alu_op1", {32'd0, alu_op1}, {32'd0, m_op1});
    chk("m_alu_op2", {32'd0, alu_op2}, {32'd0, m_op2});
    chk("m_alu_ctrl", {61'd0, alu_ctrl}, {61'd0, m_ctrl});
    if (!rst) begin
      if (m_shown && rsp_ready) m_shown = 1'b0;
      if (m_inflight) begin
        m_shown    = 1'b1;
        m_sh_id    = m_fl_id;
        m_sh_res   = m_fl_res;
        m_last     = m_fl_id;
        m_inflight = 1'b0;
      end
      if (exp_rdy != 2'b00) begin
        m_inflight = 1'b1;
        m_fl_id    = win;
        m_op1      = req_op1[win*32 +: 32];
        m_op2      = req_op2[win*32 +: 32];
        m_ctrl     = req_ctrl[win*3 +: 3];
        m_fl_res   = alu_ref(m_ctrl, m_op1, m_op2);
      end
    end
  end

  typedef struct {
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        eq;
  } vec_t;

  vec_t vecs [6];
  int   ng;

  initial begin
    vecs[0] = '{3'b000, 32'd5,         32'd7,         32'd12,        1'b0};
    vecs[1] = '{3'b001, 32'd9,         32'd9,         32'd0,         1'b1};
    vecs[2] = '{3'b101, 32'd3,         32'd5,         32'd1,         1'b0};
    vecs[3] = '{3'b011, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0};
    vecs[4] = '{3'b111, 32'd123,       32'd45,        32'd0,         1'b1};
    vecs[5] = '{3'b010, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0};

    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    req_op1 = 64'd0; req_op2 = 64'd0; req_ctrl = 6'd0;
    cyc();
    chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    cyc();
    rst = 1'b0; req_valid = 2'b00;
    cyc();

    // Single ops with literal results; grant seen in the request cycle, response two edges later.
    foreach (vecs[v]) begin
      drive(0, vecs[v].c, vecs[v].a, vecs[v].b);
      #1;
      chk("op_ready", {62'd0, req_ready}, 64'd1);
      cyc();
      req_valid = 2'b00;
      cyc();
      chk("op_valid", {63'd0, rsp_valid}, 64'd1);
      chk("op_result", {32'd0, rsp_result}, {32'd0, vecs[v].res});
      chk("op_eq", {63'd0, rsp_eq}, {63'd0, vecs[v].eq});
      chk("op_id", {63'd0, rsp_id}, 64'd0);
      cyc();
    end

    // Reset while EXEC: outputs clear asynchronously and the op is lost.
    drive(0, 3'b000, 32'd4, 32'd4);
    cyc();
    rst = 1'b1; req_valid = 2'b11;
    #1;
    chk("arst_alu_op1", {32'd0, alu_op1}, 64'd0);
    chk("arst_alu_ctrl", {61'd0, alu_ctrl}, 64'd0);
    chk("arst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("arst_req_ready", {62'd0, req_ready}, 64'd0);
    cyc();
    rst = 1'b0; req_valid = 2'b00;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("no_rsp_after_rst", {63'd0, rsp_valid}, 64'd0);
      cyc();
    end

    // Contention: requester 0 first after reset, then strict alternation.
    drive(0, 3'b000, 32'd1, 32'd2);
    drive(1, 3'b001, 32'd10, 32'd3);
    ng = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        chk("grant_seq", {62'd0, req_ready}, (ng % 2 == 0) ? 64'd1 : 64'd2);
        ng++;
      end
      cyc();
    end
    chk("grant_count", 64'(ng), 64'd4);
    req_valid = 2'b00;
    repeat (3) cyc();

    // Backpressure: response held, no grants, then immediate grant to requester 1.
    drive(0, 3'b011, 32'd1, 32'd2);
    cyc();
    req_valid = 2'b00; rsp_ready = 1'b0;
    cyc();
    drive(1, 3'b001, 32'd20, 32'd5);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("bp_result", {32'd0, rsp_result}, 64'd3);
      chk("bp_ready", {62'd0, req_ready}, 64'd0);
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", {62'd0, req_ready}, 64'd2);
    cyc();
    req_valid = 2'b00;
    cyc();
    chk("bp_next_valid", {63'd0, rsp_valid}, 64'd1);
    chk("bp_next_result", {32'd0, rsp_result}, 64'd15);
    chk("bp_next_id", {63'd0, rsp_id}, 64'd1);
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
